// File: rtl/alu_mdu_if.sv
// alu_mdu_if: valid/ready operation and result bus between the issue logic and alu_mdu
interface alu_mdu_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [5:0]            ALU_Control;
    logic [DATA_WIDTH-1:0] operand_A;
    logic [DATA_WIDTH-1:0] operand_B;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] ALU_result;
    logic                  op_illegal;
    modport master (
        output in_valid, ALU_Control, operand_A, operand_B, out_ready,
        input  in_ready, out_valid, ALU_result, op_illegal
    );
    modport slave (
        input  in_valid, ALU_Control, operand_A, operand_B, out_ready,
        output in_ready, out_valid, ALU_result, op_illegal
    );
endinterface

// File: rtl/alu_mdu.sv
// alu_mdu: single-cycle ALU plus iterative RV32M multiply/divide; define ALU_MDU_FAST_MUL_EN for a one-cycle multiplier
module alu_mdu #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input logic      clock,
    input logic      reset,
    alu_mdu_if.slave bus
);
    localparam int W = DATA_WIDTH;
    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
    state_t                 state_q;
    logic [2*W-1:0]         p_q;
    logic [W-1:0]           b_q;
    logic [W-1:0]           res_q;
    logic [SHAMT_WIDTH-1:0] cnt_q;
    logic                   div_q, neg_q, rem_q, hi_q, ill_q;
    logic [5:0]             op;
    logic [W-1:0]           a, b, a_mag, b_mag, simple_res, spec_res, load_res, mag, fix_res;
    logic [SHAMT_WIDTH-1:0] sh;
    logic                   is_mul, is_div, sa, sb, div_zero, div_ovf, iterate, legal;
    logic [W:0]             add_sum, div_shift, div_diff;
    logic [2*W-1:0]         iter_d, p_fix;
    assign op       = bus.ALU_Control;
    assign a        = bus.operand_A;
    assign b        = bus.operand_B;
    assign sh       = b[SHAMT_WIDTH-1:0];
    assign is_mul   = op[5:2] == 4'b1000;
    assign is_div   = op[5:2] == 4'b1001;
    assign sa       = is_mul ? op[1:0] != 2'b11 : !op[0];
    assign sb       = is_mul ? !op[1] : !op[0];
    assign a_mag    = (sa && a[W-1]) ? -a : a;
    assign b_mag    = (sb && b[W-1]) ? -b : b;
    assign div_zero = b == '0;
    assign div_ovf  = !op[0] && a == {1'b1, {(W-1){1'b0}}} && b == '1;
    assign spec_res = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);
`ifdef ALU_MDU_FAST_MUL_EN
    logic [2*W-1:0] fa, fb, fp, fast_res;
    assign fa       = {{W{sa && a[W-1]}}, a};
    assign fb       = {{W{sb && b[W-1]}}, b};
    assign fp       = fa * fb;
    assign fast_res = op[1:0] == 2'b00 ? {{W{1'b0}}, fp[W-1:0]} : {{W{1'b0}}, fp[2*W-1:W]};
    assign iterate  = is_div && !div_zero && !div_ovf;
    assign load_res = is_div ? spec_res : is_mul ? fast_res[W-1:0] : simple_res;
`else
    assign iterate  = is_mul || (is_div && !div_zero && !div_ovf);
    assign load_res = is_div ? spec_res : simple_res;
`endif
    // One iteration: shift-add step for multiply, restoring step for divide
    assign add_sum   = {1'b0, p_q[2*W-1:W]} + {1'b0, b_q & {W{p_q[0]}}};
    assign div_shift = p_q[2*W-1:W-1];
    assign div_diff  = div_shift - {1'b0, b_q};
    assign iter_d    = !div_q ? {add_sum, p_q[W-1:1]} :
                       div_diff[W] ? {div_shift[W-1:0], p_q[W-2:0], 1'b0} :
                                     {div_diff[W-1:0], p_q[W-2:0], 1'b1};
    // Sign fix-up: products negate the full double width, divides negate the selected half
    assign p_fix   = neg_q ? -p_q : p_q;
    assign mag     = rem_q ? p_q[2*W-1:W] : p_q[W-1:0];
    assign fix_res = div_q ? (neg_q ? -mag : mag) : (hi_q ? p_fix[2*W-1:W] : p_fix[W-1:0]);
    assign bus.in_ready  = state_q == IDLE || (state_q == DONE && bus.out_ready);
    assign bus.out_valid = state_q == DONE;
    assign bus.ALU_result = res_q;
    assign bus.op_illegal = ill_q;
    // Single-cycle operations; multiply/divide codes are legal but resolved elsewhere
    always_comb begin
        simple_res = '0;
        legal = 1'b1;
        case (op)
            6'b000000:            simple_res = a + b;
            6'b001000:            simple_res = a - b;
            6'b000010:            simple_res = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
            6'b000011, 6'b010110: simple_res = {{(W-1){1'b0}}, a < b};
            6'b010101:            simple_res = {{(W-1){1'b0}}, $signed(a) >= $signed(b)};
            6'b010111:            simple_res = {{(W-1){1'b0}}, a >= b};
            6'b000110:            simple_res = a | b;
            6'b000100:            simple_res = a ^ b;
            6'b000111:            simple_res = a & b;
            6'b000001:            simple_res = a << sh;
            6'b000101:            simple_res = a >> sh;
            6'b001101:            simple_res = $unsigned($signed(a) >>> sh);
            6'b010000:            simple_res = {{(W-1){1'b0}}, a == b};
            6'b010001:            simple_res = {{(W-1){1'b0}}, a != b};
            6'b011111, 6'b111111: simple_res = a;
            default:              legal = is_mul || is_div;
        endcase
    end
    // Handshake FSM with the multiply/divide datapath and registered result
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            p_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rem_q   <= 1'b0;
            hi_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            case (state_q)
                ITER: begin
                    p_q   <= iter_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) state_q <= FIX;
                end
                FIX: begin
                    res_q   <= fix_res;
                    state_q <= DONE;
                end
                default: begin
                    if (bus.in_valid && bus.in_ready) begin
                        if (iterate) begin
                            state_q <= ITER;
                            cnt_q   <= '1;
                            p_q     <= {{W{1'b0}}, a_mag};
                            b_q     <= b_mag;
                            div_q   <= is_div;
                            rem_q   <= op[1];
                            hi_q    <= op[1:0] != 2'b00;
                            neg_q   <= (is_div && op[1]) ? sa && a[W-1] : (sa && a[W-1]) ^ (sb && b[W-1]);
                            ill_q   <= 1'b0;
                        end else begin
                            state_q <= DONE;
                            res_q   <= legal ? load_res : '0;
                            ill_q   <= !legal;
                        end
                    end else if (state_q == DONE && bus.out_ready) begin
                        state_q <= IDLE;
                        ill_q   <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed scoreboard bench for alu_mdu
module tb_alu_mdu;
    localparam int W = 32;
`ifdef ALU_MDU_FAST_MUL_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 1;
    typedef logic [W:0] v_t;
    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b001000, SLT = 6'b000010, SLTU = 6'b000011,
                           SGE = 6'b010101, XOR = 6'b000100, SLL = 6'b000001, SRA = 6'b001101,
                           EQ = 6'b010000, PASSA = 6'b111111, MUL = 6'b100000, MULH = 6'b100001,
                           MULHSU = 6'b100010, MULHU = 6'b100011, DIV = 6'b100100, DIVU = 6'b100101,
                           REM = 6'b100110, REMU = 6'b100111;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    v_t   sb_q[$];
    v_t   exp_v;
    alu_mdu_if #(.DATA_WIDTH(W)) bus ();
    alu_mdu #(.DATA_WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;

    task automatic check(input string tag, input v_t got, input v_t exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every result taken by the consumer is compared with the oldest expectation
    always @(negedge clock) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", v_t'(sb_q.size()), v_t'(1));
            end else begin
                exp_v = sb_q.pop_front();
                check("result", {bus.op_illegal, bus.ALU_result}, exp_v);
            end
        end
    end

    task automatic send(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic ei, output int waited);
        waited = 0;
        bus.in_valid = 1'b1;
        bus.ALU_Control = op;
        bus.operand_A = a;
        bus.operand_B = b;
        #1;
        while (!bus.in_ready && waited < 200) begin
            @(posedge clock);
            #1;
            waited++;
        end
        check("in_ready_at_transfer", v_t'(bus.in_ready), v_t'(1));
        sb_q.push_back({ei, er});
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        bus.operand_A = '1;
        bus.operand_B = '1;
        bus.ALU_Control = 6'b101010;
    endtask

    task automatic wait_out(output int n, output logic saw_ready);
        n = 0;
        saw_ready = 1'b0;
        while (!bus.out_valid && n < 200) begin
            saw_ready |= bus.in_ready;
            @(posedge clock);
            #1;
            n++;
        end
    endtask

    task automatic drain();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int n;
        logic rdy;
        bus.in_valid = 1'b0;
        bus.ALU_Control = '0;
        bus.operand_A = '0;
        bus.operand_B = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset_out_valid", v_t'(bus.out_valid), v_t'(0));
        check("reset_result", v_t'(bus.ALU_result), v_t'(0));
        check("reset_illegal", v_t'(bus.op_illegal), v_t'(0));
        check("reset_in_ready", v_t'(bus.in_ready), v_t'(1));
        // Back-to-back simple ops, one per cycle
        send(ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, n);
        check("add_valid_n1", v_t'(bus.out_valid), v_t'(1));
        send(SRA, 32'h80000000, 32'h24, 32'hF8000000, 1'b0, n);
        check("sra_no_stall", v_t'(n), v_t'(0));
        send(SLTU, 32'h1, 32'hFFFFFFFF, 32'h1, 1'b0, n);
        check("sltu_no_stall", v_t'(n), v_t'(0));
        send(SLT, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, n);
        send(SGE, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, n);
        send(SUB, 32'h0, 32'h1, 32'hFFFFFFFF, 1'b0, n);
        send(XOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, n);
        send(SLL, 32'h00000001, 32'hFFFFFFE3, 32'h00000008, 1'b0, n);
        send(EQ, 32'h1234, 32'h1234, 32'h1, 1'b0, n);
        send(PASSA, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 1'b0, n);
        check("simple_valid", v_t'(bus.out_valid), v_t'(1));
        // Multiplies
        send(MUL, 32'd3, 32'd5, 32'h0000000F, 1'b0, n);
        wait_out(n, rdy);
        check("mul_latency", v_t'(n), v_t'(MUL_LAT));
        send(MULH, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, n);
        wait_out(n, rdy);
        send(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, n);
        wait_out(n, rdy);
        send(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, n);
        wait_out(n, rdy);
        send(MUL, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 1'b0, n);
        wait_out(n, rdy);
        // Divides
        send(DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, n);
        wait_out(n, rdy);
        check("div_latency", v_t'(n), v_t'(DIV_LAT));
        check("div_in_ready_low", v_t'(rdy), v_t'(0));
        send(REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, n);
        wait_out(n, rdy);
        send(DIVU, 32'd100, 32'd7, 32'd14, 1'b0, n);
        wait_out(n, rdy);
        send(REMU, 32'd100, 32'd7, 32'd2, 1'b0, n);
        wait_out(n, rdy);
        // Divide special cases take the one-cycle path
        send(DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b0, n);
        check("div0_valid_n1", v_t'(bus.out_valid), v_t'(1));
        send(REMU, 32'd5, 32'd0, 32'd5, 1'b0, n);
        check("remu0_no_stall", v_t'(n), v_t'(0));
        send(DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, n);
        check("divovf_valid_n1", v_t'(bus.out_valid), v_t'(1));
        send(REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, n);
        // Illegal code
        send(6'b101010, 32'h55, 32'h66, 32'h0, 1'b1, n);
        check("illegal_valid_n1", v_t'(bus.out_valid), v_t'(1));
        drain();
        // Backpressure holds the result
        bus.out_ready = 1'b0;
        send(DIVU, 32'd100, 32'd7, 32'd14, 1'b0, n);
        wait_out(n, rdy);
        repeat (5) begin
            check("bp_result", v_t'(bus.ALU_result), v_t'(14));
            check("bp_valid", v_t'(bus.out_valid), v_t'(1));
            check("bp_in_ready", v_t'(bus.in_ready), v_t'(0));
            @(posedge clock);
            #1;
        end
        bus.out_ready = 1'b1;
        drain();
        check("bp_released", v_t'(bus.out_valid), v_t'(0));
        // Reset in the middle of a divide
        send(DIV, 32'd100, 32'd7, 32'd14, 1'b0, n);
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rst_out_valid", v_t'(bus.out_valid), v_t'(0));
        check("rst_result", v_t'(bus.ALU_result), v_t'(0));
        check("rst_in_ready", v_t'(bus.in_ready), v_t'(1));
        sb_q.delete();
        reset = 1'b0;
        send(ADD, 32'd2, 32'd2, 32'd4, 1'b0, n);
        check("post_rst_valid_n1", v_t'(bus.out_valid), v_t'(1));
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("scoreboard_empty", v_t'(sb_q.size()), v_t'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
